// File: rtl/alu_path_ctrl_if.sv
// Control bundle between the multicycle ALU controller and its datapath.
// master = controller (reads IR fields/zero, drives selects and strobes); slave = datapath.
interface alu_path_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [2:0] alu_op;
    logic [1:0] pc_src_sel;
    logic       pc_write;
    logic       ir_write;
    logic       mem_rd;
    logic       reg_write;
    logic       a_load;
    logic       b_load;
    logic       alu_out_load;
    logic       reg_dst_sel;
    logic       illegal;

    modport master (
        input  opcode, funct, zero,
        output alu_a_sel, alu_b_sel, alu_op, pc_src_sel,
        output pc_write, ir_write, mem_rd, reg_write,
        output a_load, b_load, alu_out_load, reg_dst_sel, illegal
    );

    modport slave (
        output opcode, funct, zero,
        input  alu_a_sel, alu_b_sel, alu_op, pc_src_sel,
        input  pc_write, ir_write, mem_rd, reg_write,
        input  a_load, b_load, alu_out_load, reg_dst_sel, illegal
    );
endinterface

// File: rtl/alu_path_ctrl.sv
// Multicycle fetch/decode/execute/writeback controller for the ALU datapath.
// Ports: clk, reset_n (async active-low), bus (alu_path_ctrl_if.master: IR fields, zero in; selects/strobes out).
module alu_path_ctrl #(
    parameter int MEM_WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_path_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL
    } state_t;

    localparam logic [2:0] LP_WAIT = 3'(MEM_WAIT_CYCLES);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_wait;
    logic [2:0] w_wait_nxt;
    logic       w_r_ok;
    logic       w_fetch_done;

    assign w_r_ok = (bus.opcode == 6'h00) &&
                    ((bus.funct == 6'h20) ||
                     (bus.funct == 6'h22) ||
                     (bus.funct == 6'h24));

    assign w_fetch_done = (r_wait == LP_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RST;
            r_wait  <= 3'd0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_wait_nxt       = 3'd0;
        bus.alu_a_sel    = 2'b00;
        bus.alu_b_sel    = 2'b00;
        bus.alu_op       = 3'b000;
        bus.pc_src_sel   = 2'b00;
        bus.pc_write     = 1'b0;
        bus.ir_write     = 1'b0;
        bus.mem_rd       = 1'b0;
        bus.reg_write    = 1'b0;
        bus.a_load       = 1'b0;
        bus.b_load       = 1'b0;
        bus.alu_out_load = 1'b0;
        bus.reg_dst_sel  = 1'b0;
        bus.illegal      = 1'b0;

        unique case (r_state)
            S_RST: w_next = S_FETCH;
            S_FETCH: begin
                bus.mem_rd    = 1'b1;
                bus.alu_b_sel = 2'b01;
                bus.alu_op    = 3'b001;
                if (w_fetch_done) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    w_next       = S_DECODE;
                end else begin
                    w_wait_nxt = r_wait + 3'd1;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut
                bus.a_load       = 1'b1;
                bus.b_load       = 1'b1;
                bus.alu_out_load = 1'b1;
                bus.alu_b_sel    = 2'b11;
                bus.alu_op       = 3'b001;
                if (w_r_ok)
                    w_next = S_EXEC_R;
                else if (bus.opcode == 6'h08)
                    w_next = S_EXEC_I;
                else if ((bus.opcode == 6'h04) || (bus.opcode == 6'h05))
                    w_next = S_BRANCH;
                else if (bus.opcode == 6'h02)
                    w_next = S_JUMP;
                else
                    w_next = S_ILLEGAL;
            end
            S_EXEC_R: begin
                bus.alu_a_sel    = 2'b01;
                bus.alu_out_load = 1'b1;
                case (bus.funct)
                    6'h20:   bus.alu_op = 3'b001;
                    6'h22:   bus.alu_op = 3'b010;
                    6'h24:   bus.alu_op = 3'b011;
                    default: bus.alu_op = 3'b000;
                endcase
                w_next = S_WB_R;
            end
            S_WB_R: begin
                bus.reg_write   = 1'b1;
                bus.reg_dst_sel = 1'b1;
                w_next          = S_FETCH;
            end
            S_EXEC_I: begin
                bus.alu_a_sel    = 2'b01;
                bus.alu_b_sel    = 2'b10;
                bus.alu_op       = 3'b001;
                bus.alu_out_load = 1'b1;
                w_next           = S_WB_I;
            end
            S_WB_I: begin
                bus.reg_write = 1'b1;
                w_next        = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_a_sel  = 2'b01;
                bus.alu_op     = 3'b010;
                bus.pc_src_sel = 2'b01;
                // beq takes on zero, bne on non-zero
                bus.pc_write   = ((bus.opcode == 6'h04) &&  bus.zero) ||
                                 ((bus.opcode == 6'h05) && !bus.zero);
                w_next         = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_src_sel = 2'b10;
                bus.pc_write   = 1'b1;
                w_next         = S_FETCH;
            end
            S_ILLEGAL: bus.illegal = 1'b1;
            default:   w_next = S_RST;
        endcase
    end

endmodule

// File: tb/tb_alu_path_ctrl.sv
// Self-checking bench for alu_path_ctrl: vector table, random instruction stream,
// and hand-written reset/illegal/zero-wait sequences against an instruction-level model.
module tb_alu_path_ctrl;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    alu_path_ctrl_if if0();
    alu_path_ctrl_if if1();

    alu_path_ctrl #(.MEM_WAIT_CYCLES(2)) u0 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (if0.master)
    );

    alu_path_ctrl #(.MEM_WAIT_CYCLES(0)) u1 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (if1.master)
    );

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] op;
        logic [1:0] pcs;
        logic       pcw;
        logic       irw;
        logic       mrd;
        logic       rw;
        logic       al;
        logic       bl;
        logic       aol;
        logic       rd;
        logic       ill;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         len;
        int         pcw;
        int         rw;
        int         xop;
    } vec_t;

    int    vectors    = 0;
    int    miscompares = 0;
    outs_t exp_q[$];

    function automatic outs_t get(int w);
        outs_t o;
        if (w == 0) begin
            o = {if0.alu_a_sel, if0.alu_b_sel, if0.alu_op, if0.pc_src_sel,
                 if0.pc_write, if0.ir_write, if0.mem_rd, if0.reg_write,
                 if0.a_load, if0.b_load, if0.alu_out_load, if0.reg_dst_sel,
                 if0.illegal};
        end else begin
            o = {if1.alu_a_sel, if1.alu_b_sel, if1.alu_op, if1.pc_src_sel,
                 if1.pc_write, if1.ir_write, if1.mem_rd, if1.reg_write,
                 if1.a_load, if1.b_load, if1.alu_out_load, if1.reg_dst_sel,
                 if1.illegal};
        end
        return o;
    endfunction

    task automatic check(string name, outs_t act, outs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic outs_t fetch_cyc(bit last);
        outs_t o = '0;
        o.mrd = 1'b1;
        o.b   = 2'b01;
        o.op  = 3'b001;
        o.irw = last;
        o.pcw = last;
        return o;
    endfunction

    // Instruction-level model: list of expected output words, one per cycle
    task automatic build(logic [5:0] op, logic [5:0] fn, logic z, int F);
        outs_t o;
        bit    is_r;
        is_r = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
        exp_q.delete();
        for (int i = 0; i < F; i++) exp_q.push_back(fetch_cyc(i == F - 1));
        o = '0; o.al = 1; o.bl = 1; o.aol = 1; o.b = 2'b11; o.op = 3'd1;
        exp_q.push_back(o);
        if (is_r) begin
            o = '0; o.a = 2'b01; o.aol = 1;
            o.op = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3;
            exp_q.push_back(o);
            o = '0; o.rw = 1; o.rd = 1;
            exp_q.push_back(o);
        end else if (op == 6'h08) begin
            o = '0; o.a = 2'b01; o.b = 2'b10; o.op = 3'd1; o.aol = 1;
            exp_q.push_back(o);
            o = '0; o.rw = 1;
            exp_q.push_back(o);
        end else if (op == 6'h04 || op == 6'h05) begin
            o = '0; o.a = 2'b01; o.op = 3'd2; o.pcs = 2'b01;
            o.pcw = (op == 6'h04) ? z : !z;
            exp_q.push_back(o);
        end else if (op == 6'h02) begin
            o = '0; o.pcs = 2'b10; o.pcw = 1;
            exp_q.push_back(o);
        end else begin
            o = '0; o.ill = 1;
            exp_q.push_back(o);
        end
    endtask

    task automatic drive(int w, logic [5:0] op, logic [5:0] fn, logic z);
        if (w == 0) begin
            if0.opcode = op; if0.funct = fn; if0.zero = z;
        end else begin
            if1.opcode = op; if1.funct = fn; if1.zero = z;
        end
    endtask

    // Entered at the negedge of the first FETCH cycle; leaves at the next one
    task automatic run_instr(string name, int w, logic [5:0] op,
                             logic [5:0] fn, logic z, int F,
                             output int len, output int pcw,
                             output int rw, output int xop);
        outs_t o;
        bit    prev;
        drive(w, op, fn, z);
        build(op, fn, z, F);
        len = -1; pcw = 0; rw = 0; xop = 0; prev = 1'b1;
        for (int c = 0; c < 32; c++) begin
            o = get(w);
            if (c > 0 && o.mrd && !prev) begin
                len = c;
                break;
            end
            if (c < exp_q.size()) begin
                check($sformatf("%s cyc%0d", name, c), o, exp_q[c]);
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL %s cyc%0d: got %h want fetch", name, c, o);
            end
            if (!o.mrd && o.pcw) pcw++;
            if (o.rw) rw++;
            if (o.aol && o.a == 2'b01) xop = int'(o.op);
            prev = o.mrd;
            @(negedge clk);
        end
        if (len < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got no refetch want refetch", name);
        end
    endtask

    task automatic reset_tail();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_cycle u0", get(0), '0);
        check("rst_cycle u1", get(1), '0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_async u0", get(0), '0);
        check("rst_async u1", get(1), '0);
        reset_tail();
    endtask

    vec_t tbl[10];

    initial begin
        int len, pcw, rw, xop;
        logic [5:0] op, fn;
        logic z;
        int cls;

        tbl[0] = '{"add",    6'h00, 6'h20, 1'b0, 6, 0, 1, 1};
        tbl[1] = '{"sub",    6'h00, 6'h22, 1'b1, 6, 0, 1, 2};
        tbl[2] = '{"and",    6'h00, 6'h24, 1'b0, 6, 0, 1, 3};
        tbl[3] = '{"addi",   6'h08, 6'h11, 1'b0, 6, 0, 1, 1};
        tbl[4] = '{"beq_t",  6'h04, 6'h00, 1'b1, 5, 1, 0, 0};
        tbl[5] = '{"beq_nt", 6'h04, 6'h00, 1'b0, 5, 0, 0, 0};
        tbl[6] = '{"bne_t",  6'h05, 6'h00, 1'b0, 5, 1, 0, 0};
        tbl[7] = '{"bne_nt", 6'h05, 6'h00, 1'b1, 5, 0, 0, 0};
        tbl[8] = '{"j",      6'h02, 6'h3f, 1'b0, 5, 1, 0, 0};
        tbl[9] = '{"addz",   6'h00, 6'h20, 1'b1, 6, 0, 1, 1};

        drive(0, 6'h00, 6'h20, 1'b0);
        drive(1, 6'h02, 6'h00, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        do_reset();

        foreach (tbl[i]) begin
            run_instr(tbl[i].name, 0, tbl[i].op, tbl[i].fn, tbl[i].z, 3,
                      len, pcw, rw, xop);
            check_int({tbl[i].name, ".len"}, len, tbl[i].len);
            check_int({tbl[i].name, ".pcw"}, pcw, tbl[i].pcw);
            check_int({tbl[i].name, ".rw"},  rw,  tbl[i].rw);
            check_int({tbl[i].name, ".xop"}, xop, tbl[i].xop);
        end

        for (int k = 0; k < 40; k++) begin
            cls = int'($urandom_range(0, 4));
            fn  = 6'($urandom);
            z   = 1'($urandom);
            case (cls)
                0: begin
                    op = 6'h00;
                    case ($urandom_range(0, 2))
                        0: fn = 6'h20;
                        1: fn = 6'h22;
                        default: fn = 6'h24;
                    endcase
                end
                1: op = 6'h08;
                2: op = 6'h04;
                3: op = 6'h05;
                default: op = 6'h02;
            endcase
            run_instr($sformatf("rnd%0d", k), 0, op, fn, z, 3,
                      len, pcw, rw, xop);
            check_int($sformatf("rnd%0d.len", k), len, exp_q.size());
        end

        drive(0, 6'h08, 6'h00, 1'b0);
        build(6'h08, 6'h00, 1'b0, 3);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("addi_pre cyc%0d", c), get(0), exp_q[c]);
            if (c < 4) @(negedge clk);
        end
        do_reset();
        run_instr("addi_post", 0, 6'h08, 6'h00, 1'b0, 3, len, pcw, rw, xop);
        check_int("addi_post.len", len, 6);
        check_int("addi_post.rw", rw, 1);

        drive(0, 6'h3f, 6'h00, 1'b0);
        build(6'h3f, 6'h00, 1'b0, 3);
        for (int c = 0; c < 24; c++) begin
            check($sformatf("illegal cyc%0d", c), get(0),
                  exp_q[(c < exp_q.size()) ? c : exp_q.size() - 1]);
            @(negedge clk);
        end
        do_reset();

        for (int k = 0; k < 5; k++) begin
            run_instr($sformatf("j0_%0d", k), 1, 6'h02, 6'h00, 1'b0, 1,
                      len, pcw, rw, xop);
            check_int($sformatf("j0_%0d.len", k), len, 3);
            check_int($sformatf("j0_%0d.pcw", k), pcw, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
